memory_stage: RTL and testbench
===============================

Name: memory_stage

Overview:
- M stage of the five-stage MIPS pipeline.
- Owns the data memory (DM) and performs loads and stores for the instruction currently in M.
- Holds the M/W pipeline register, so its registered outputs feed the Writeback stage directly.
- The Writeback stage then selects between ALUOut_W and ReadData_W.

Parameters:
- DM_WORDS, 3072, number of 32-bit DM words (byte range 0x0000–0x2FFF).
- DM_AW, 12, word-index width; must satisfy 2^DM_AW >= DM_WORDS.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset (asserted when 0)
- Instr_M  input  32  instruction in M
- PC_M  input  32  PC of instruction in M
- ALUOut_M  input  32  ALU result; byte address for loads/stores
- WriteData_M  input  32  rt value after M-stage forwarding
- WriteReg_M  input  5  destination register
- Instr_W  output  32  registered Instr_M
- PC_W  output  32  registered PC_M
- ALUOut_W  output  32  registered ALUOut_M
- ReadData_W  output  32  registered, extended load data
- WriteReg_W  output  5  registered WriteReg_M

Behaviour:
- Opcode decode uses Instr_M[31:26].
  - Loads: lw 100011, lh 100001, lhu 100101, lb 100000, lbu 100100.
  - Stores: sw 101011, sh 101001, sb 101000.
  - Any other opcode performs no memory access.
- Addressing: word index = ALUOut_M[DM_AW+1:2]; byte offset = ALUOut_M[1:0].
- Store byte enables:
  - sw writes all four bytes.
  - sh writes bytes {1,0} when ALUOut_M[1]=0, and bytes {3,2} when ALUOut_M[1]=1.
  - sb writes the byte selected by the offset.
  - Stored data is WriteData_M's low lane, replicated into the selected lanes.
- Little-endian lanes: byte 0 = bits [7:0].
- Store timing: the DM write commits at the clk edge ending the M cycle.
- Store trace: on each committed store, $display prints "%d@%h: *%h <= %h" with $time, PC_M, the word-aligned byte address, and the full merged word after the write.
- Load read path:
  - DM read is combinational from the word index.
  - lw returns the word.
  - lh/lhu select the half by ALUOut_M[1]; lb/lbu select the byte by the offset.
  - lh/lb sign-extend; lhu/lbu zero-extend.
- Load result for non-load opcodes: the load mux outputs 0.
- Misaligned access:
  - sw/lw with offset != 0, or sh/lh/lhu with offset[0]=1, is misaligned.
  - A misaligned store is suppressed: no write, no display.
  - A misaligned load yields 0.
- Out-of-range access: word index >= DM_WORDS suppresses stores and makes loads yield 0.
- M/W register:
  - Every clk edge with reset=1 latches Instr, PC, ALUOut, the extended read data, and WriteReg into the W outputs.
  - Latency is exactly 1 cycle.
  - There is no stall or enable input; the M/W register never stalls in this pipeline.
- Reset (reset=0 at clk edge):
  - All W outputs become 0; Instr_W=0 decodes as nop.
  - All DM words become 0.
  - A store presented in M during the reset cycle is dropped, reset has priority, and no display occurs.
  - Reset takes effect mid-program the same way.
- Store then load to the same address in consecutive cycles: the load observes the new data (write committed at the prior edge).
- Outputs change only at clk edges; there is no combinational path from inputs to outputs.

Decomposition:
- Shared package/header holds:
  - opcode constants OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU, OP_SW, OP_SH, OP_SB;
  - DM_WORDS default;
  - a LOAD_TYPE encoding: WORD, HALF_S, HALF_U, BYTE_S, BYTE_U, NONE.
- Sub-module dm: byte-enabled synchronous-write, async-read RAM with reset clear and the store $display.
- Decode, byte-lane steering, load extension, and the M/W register stay in memory_stage.

Test Plan:
- Reset held low 2 cycles with Instr_M=sw: all W outputs read 0 afterward; DM[0] reads 0; no display printed.
- sw at addr 0x10 with data 0x12345678 (PC_M 0x3000), next cycle lw 0x10: display shows "@00003000: *00000010 <= 12345678", and the cycle after, ReadData_W=0x12345678.
- With word 0x10 = 0x12345678:
  - sb 0x11 with data 0x000000AB makes the word 0x1234AB78;
  - sh 0x12 with data 0x0000CDEF makes it 0xCDEFAB78.
- With word 0x20 = 0x80FF7F01:
  - lb 0x22 -> 0xFFFFFFFF; lbu 0x22 -> 0x000000FF;
  - lh 0x22 -> 0xFFFF80FF; lhu 0x22 -> 0x000080FF;
  - lb 0x21 -> 0x0000007F.
- Misaligned and out-of-range accesses:
  - sw 0x13 leaves the word unchanged with no display; lw 0x13 -> 0.
  - sw at byte address 0x3000 is suppressed.
- Pass-through with Instr_M=addu, ALUOut_M=0x55, WriteReg_M=8, PC_M=0x3004: after one edge, ALUOut_W=0x55, WriteReg_W=8, PC_W=0x3004, ReadData_W=0.

Source files
------------

// File: rtl/memory_stage_pkg.sv
// Shared definitions for the MIPS M stage: opcode constants, default DM size
// and the load-type encoding used by the load extension path.
package memory_stage_pkg;

  localparam int DM_WORDS_DEFAULT = 3072;

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SB  = 6'b101000;

  typedef enum logic [2:0] {
    WORD,
    HALF_S,
    HALF_U,
    BYTE_S,
    BYTE_U,
    NONE
  } load_type_e;

endpackage

// File: rtl/memory_stage_dm.sv
// Data memory: byte-enabled synchronous write, asynchronous read, cleared by
// reset, with a trace line printed for every committed store.
module dm #(
  parameter int DM_WORDS = 3072,
  parameter int DM_AW    = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [DM_AW-1:0]  addr,
  input  logic [31:0]       wdata,
  input  logic [31:0]       pc,
  output logic [31:0]       rdata
);

  localparam logic [DM_AW:0] DM_LIMIT = DM_WORDS[DM_AW:0];

  logic [31:0] mem [0:DM_WORDS-1];
  logic [31:0] merged;
  logic [31:0] byte_addr;

  assign rdata     = ({1'b0, addr} < DM_LIMIT) ? mem[addr] : '0;
  assign byte_addr = 32'({addr, 2'b00});

  always_comb begin
    merged = rdata;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merged[8*i +: 8] = wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DM_WORDS; i++) mem[i] <= '0;
    end else if (we) begin
      mem[addr] <= merged;
      $display("%d@%h: *%h <= %h", $time, pc, byte_addr, merged);
    end
  end

endmodule

// File: rtl/memory_stage.sv
// M stage of the five-stage MIPS pipeline: load/store decode, byte-lane
// steering into the data memory, load extension and the M/W register.
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int DM_WORDS = DM_WORDS_DEFAULT,
  parameter int DM_AW    = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr_M,
  input  logic [31:0] PC_M,
  input  logic [31:0] ALUOut_M,
  input  logic [31:0] WriteData_M,
  input  logic [4:0]  WriteReg_M,
  output logic [31:0] Instr_W,
  output logic [31:0] PC_W,
  output logic [31:0] ALUOut_W,
  output logic [31:0] ReadData_W,
  output logic [4:0]  WriteReg_W
);

  localparam logic [DM_AW:0] DM_LIMIT = DM_WORDS[DM_AW:0];

  logic [5:0]       op_p0;
  logic [DM_AW-1:0] widx_p0;
  logic [1:0]       off_p0;
  logic             in_range_p0;
  load_type_e       ld_type_p0;
  logic             st_p0;
  logic             misal_p0;
  logic [3:0]       st_be_p0;
  logic [31:0]      st_data_p0;
  logic             dm_we_p0;
  logic [31:0]      dm_rdata_p0;
  logic [31:0]      rd_ext_p0;
  logic             unused_addr_hi;

  assign op_p0          = Instr_M[31:26];
  assign widx_p0        = ALUOut_M[DM_AW+1:2];
  assign off_p0         = ALUOut_M[1:0];
  assign in_range_p0    = ({1'b0, widx_p0} < DM_LIMIT);
  assign unused_addr_hi = ^ALUOut_M[31:DM_AW+2];

  function automatic logic [31:0] extend_load(input load_type_e t,
                                              input logic [31:0] w,
                                              input logic [1:0]  off);
    logic [15:0] h;
    logic [7:0]  b;
    h = off[1] ? w[31:16] : w[15:0];
    b = w[8*off +: 8];
    case (t)
      WORD:    return w;
      HALF_S:  return {{16{h[15]}}, h};
      HALF_U:  return {16'h0000, h};
      BYTE_S:  return {{24{b[7]}}, b};
      BYTE_U:  return {24'h000000, b};
      default: return '0;
    endcase
  endfunction

  always_comb begin
    ld_type_p0 = NONE;
    st_p0      = 1'b0;
    misal_p0   = 1'b0;
    st_be_p0   = 4'b0000;
    st_data_p0 = WriteData_M;
    case (op_p0)
      OP_LW:  begin ld_type_p0 = WORD;   misal_p0 = (off_p0 != 2'b00); end
      OP_LH:  begin ld_type_p0 = HALF_S; misal_p0 = off_p0[0];         end
      OP_LHU: begin ld_type_p0 = HALF_U; misal_p0 = off_p0[0];         end
      OP_LB:  ld_type_p0 = BYTE_S;
      OP_LBU: ld_type_p0 = BYTE_U;
      OP_SW: begin
        st_p0    = 1'b1;
        st_be_p0 = 4'b1111;
        misal_p0 = (off_p0 != 2'b00);
      end
      OP_SH: begin
        st_p0      = 1'b1;
        st_be_p0   = off_p0[1] ? 4'b1100 : 4'b0011;
        st_data_p0 = {2{WriteData_M[15:0]}};
        misal_p0   = off_p0[0];
      end
      OP_SB: begin
        st_p0      = 1'b1;
        st_be_p0   = 4'b0001 << off_p0;
        st_data_p0 = {4{WriteData_M[7:0]}};
      end
      default: ;
    endcase
  end

  // Misaligned or out-of-range stores are dropped; such loads read as zero.
  assign dm_we_p0  = st_p0 && !misal_p0 && in_range_p0;
  assign rd_ext_p0 = (in_range_p0 && !misal_p0)
                     ? extend_load(ld_type_p0, dm_rdata_p0, off_p0) : '0;

  dm #(
    .DM_WORDS(DM_WORDS),
    .DM_AW   (DM_AW)
  ) u_dm (
    .clk  (clk),
    .reset(reset),
    .we   (dm_we_p0),
    .be   (st_be_p0),
    .addr (widx_p0),
    .wdata(st_data_p0),
    .pc   (PC_M),
    .rdata(dm_rdata_p0)
  );

  // M/W pipeline register
  always_ff @(posedge clk) begin
    if (!reset) begin
      Instr_W    <= '0;
      PC_W       <= '0;
      ALUOut_W   <= '0;
      ReadData_W <= '0;
      WriteReg_W <= '0;
    end else begin
      Instr_W    <= Instr_M;
      PC_W       <= PC_M;
      ALUOut_W   <= ALUOut_M;
      ReadData_W <= rd_ext_p0;
      WriteReg_W <= WriteReg_M;
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Randomized bench for memory_stage against a byte-addressed reference model.
module tb_memory_stage;
  import memory_stage_pkg::*;

  localparam int NWORDS = 3072;
  localparam logic [5:0] OP_SPECIAL = 6'b000000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Instr_M, PC_M, ALUOut_M, WriteData_M;
  logic [4:0]  WriteReg_M;
  logic [31:0] Instr_W, PC_W, ALUOut_W, ReadData_W;
  logic [4:0]  WriteReg_W;

  memory_stage #(.DM_WORDS(NWORDS), .DM_AW(12)) dut (
    .clk        (clk),
    .reset      (reset),
    .Instr_M    (Instr_M),
    .PC_M       (PC_M),
    .ALUOut_M   (ALUOut_M),
    .WriteData_M(WriteData_M),
    .WriteReg_M (WriteReg_M),
    .Instr_W    (Instr_W),
    .PC_W       (PC_W),
    .ALUOut_W   (ALUOut_W),
    .ReadData_W (ReadData_W),
    .WriteReg_W (WriteReg_W)
  );

  always #5 clk = ~clk;

  logic [7:0] ref_b [0:NWORDS*4-1];
  logic [5:0] ops [9] = '{OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU,
                          OP_SW, OP_SH, OP_SB, OP_SPECIAL};
  int n_pass = 0;
  int n_chk  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic int op_size(input logic [5:0] op);
    case (op)
      OP_LW, OP_SW:         return 4;
      OP_LH, OP_LHU, OP_SH: return 2;
      OP_LB, OP_LBU, OP_SB: return 1;
      default:              return 0;
    endcase
  endfunction

  function automatic bit is_load(input logic [5:0] op);
    return op inside {OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU};
  endfunction

  function automatic bit is_store(input logic [5:0] op);
    return op inside {OP_SW, OP_SH, OP_SB};
  endfunction

  function automatic logic [31:0] model_load(input logic [5:0] op, input logic [31:0] a);
    int sz, ea;
    logic [31:0] v;
    if (!is_load(op)) return '0;
    sz = op_size(op);
    ea = int'(a[13:0]);
    if (ea / 4 >= NWORDS) return '0;
    if (ea % sz != 0) return '0;
    v = '0;
    for (int k = 0; k < sz; k++) v = v | (32'(ref_b[ea+k]) << (8*k));
    if ((op == OP_LH || op == OP_LB) && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8*sz));
    return v;
  endfunction

  task automatic model_store(input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd);
    int sz, ea;
    if (!is_store(op)) return;
    sz = op_size(op);
    ea = int'(a[13:0]);
    if (ea / 4 >= NWORDS || ea % sz != 0) return;
    for (int k = 0; k < sz; k++) ref_b[ea+k] = 8'(wd >> (8*k));
  endtask

  task automatic model_clear();
    for (int i = 0; i < NWORDS*4; i++) ref_b[i] = 8'h00;
  endtask

  task automatic step(input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] pc, input logic [4:0] wr);
    logic [31:0] instr, exp_rd;
    instr       = {op, 26'($urandom)};
    reset       = 1'b1;
    Instr_M     = instr;
    PC_M        = pc;
    ALUOut_M    = a;
    WriteData_M = wd;
    WriteReg_M  = wr;
    exp_rd      = model_load(op, a);
    @(posedge clk);
    #1;
    model_store(op, a, wd);
    check("instr_w", Instr_W, instr);
    check("pc_w", PC_W, pc);
    check("aluout_w", ALUOut_W, a);
    check("writereg_w", {27'b0, WriteReg_W}, {27'b0, wr});
    check("readdata_w", ReadData_W, exp_rd);
  endtask

  task automatic rst_step(input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd);
    reset       = 1'b0;
    Instr_M     = {op, 26'h0};
    PC_M        = 32'h0000_3000;
    ALUOut_M    = a;
    WriteData_M = wd;
    WriteReg_M  = 5'd31;
    @(posedge clk);
    #1;
    model_clear();
    check("rst_instr_w", Instr_W, '0);
    check("rst_pc_w", PC_W, '0);
    check("rst_aluout_w", ALUOut_W, '0);
    check("rst_readdata_w", ReadData_W, '0);
    check("rst_writereg_w", {27'b0, WriteReg_W}, '0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    Instr_M = '0; PC_M = '0; ALUOut_M = '0; WriteData_M = '0; WriteReg_M = '0;
    model_clear();

    rst_step(OP_SW, 32'h0, 32'hDEAD_BEEF);
    rst_step(OP_SW, 32'h0, 32'hDEAD_BEEF);
    step(OP_LW, 32'h0, 32'h0, 32'h3000, 5'd1);
    check("dm0_after_reset", ReadData_W, 32'h0);

    step(OP_SW, 32'h10, 32'h1234_5678, 32'h3000, 5'd0);
    step(OP_LW, 32'h10, 32'h0, 32'h3004, 5'd2);
    check("sw_lw_0x10", ReadData_W, 32'h1234_5678);
    step(OP_SB, 32'h11, 32'h0000_00AB, 32'h3008, 5'd0);
    step(OP_LW, 32'h10, 32'h0, 32'h300C, 5'd2);
    check("sb_0x11", ReadData_W, 32'h1234_AB78);
    step(OP_SH, 32'h12, 32'h0000_CDEF, 32'h3010, 5'd0);
    step(OP_LW, 32'h10, 32'h0, 32'h3014, 5'd2);
    check("sh_0x12", ReadData_W, 32'hCDEF_AB78);

    step(OP_SW, 32'h20, 32'h80FF_7F01, 32'h3018, 5'd0);
    step(OP_LB, 32'h22, 32'h0, 32'h301C, 5'd3);
    check("lb_0x22", ReadData_W, 32'hFFFF_FFFF);
    step(OP_LBU, 32'h22, 32'h0, 32'h3020, 5'd3);
    check("lbu_0x22", ReadData_W, 32'h0000_00FF);
    step(OP_LH, 32'h22, 32'h0, 32'h3024, 5'd3);
    check("lh_0x22", ReadData_W, 32'hFFFF_80FF);
    step(OP_LHU, 32'h22, 32'h0, 32'h3028, 5'd3);
    check("lhu_0x22", ReadData_W, 32'h0000_80FF);
    step(OP_LB, 32'h21, 32'h0, 32'h302C, 5'd3);
    check("lb_0x21", ReadData_W, 32'h0000_007F);

    step(OP_SW, 32'h13, 32'hFFFF_FFFF, 32'h3030, 5'd0);
    step(OP_LW, 32'h10, 32'h0, 32'h3034, 5'd4);
    check("misaligned_sw_kept", ReadData_W, 32'hCDEF_AB78);
    step(OP_LW, 32'h13, 32'h0, 32'h3038, 5'd4);
    check("misaligned_lw", ReadData_W, 32'h0);
    step(OP_SW, 32'h3000, 32'h5A5A_5A5A, 32'h303C, 5'd0);
    step(OP_LW, 32'h3000, 32'h0, 32'h3040, 5'd4);
    check("oor_lw", ReadData_W, 32'h0);
    step(OP_LW, 32'h0, 32'h0, 32'h3044, 5'd4);
    check("oor_sw_no_alias", ReadData_W, 32'h0);
    step(OP_SW, 32'h2FFC, 32'hC0FF_EE11, 32'h3048, 5'd0);
    step(OP_LHU, 32'h2FFE, 32'h0, 32'h304C, 5'd4);
    check("last_word_lhu", ReadData_W, 32'h0000_C0FF);

    step(OP_SPECIAL, 32'h55, 32'h1111_2222, 32'h3004, 5'd8);
    check("addu_aluout", ALUOut_W, 32'h55);
    check("addu_writereg", {27'b0, WriteReg_W}, 32'd8);
    check("addu_pc", PC_W, 32'h3004);
    check("addu_readdata", ReadData_W, 32'h0);

    for (int i = 0; i < 600; i++) begin
      logic [31:0] a;
      if ($urandom_range(0, 9) == 0) a = 32'h2FF0 + $urandom_range(0, 31);
      else a = $urandom_range(0, 63);
      if ($urandom_range(0, 59) == 0)
        rst_step(OP_SW, a, $urandom);
      else
        step(ops[$urandom_range(0, 8)], a, $urandom, 32'h3000 + 32'(4*i), 5'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
